// File: rtl/saber_action_controller_if.sv
// saber_action_controller_if: button/frame inputs and action status outputs of one player's saber sequencer
interface saber_action_controller_if;
    logic       new_frame_in;
    logic       attack_btn_in;
    logic       block_btn_in;
    logic       hit_landed_in;
    logic       is_attacking;
    logic       is_blocking;
    logic [2:0] state_out;
    logic [7:0] phase_count_out;
    logic [7:0] attack_count_out;

    modport master (
        output new_frame_in, attack_btn_in, block_btn_in, hit_landed_in,
        input  is_attacking, is_blocking, state_out, phase_count_out, attack_count_out
    );

    modport slave (
        input  new_frame_in, attack_btn_in, block_btn_in, hit_landed_in,
        output is_attacking, is_blocking, state_out, phase_count_out, attack_count_out
    );
endinterface

// File: rtl/saber_action_controller.sv
// saber_action_controller: frame-timed attack/block sequencer for one player (optional SABER_ATTACK_BUFFER_EN)
module saber_action_controller #(
    parameter int WINDUP_FRAMES    = 4,
    parameter int ATTACK_FRAMES    = 6,
    parameter int RECOVER_FRAMES   = 10,
    parameter int BLOCK_MAX_FRAMES = 30,
    parameter int BLOCK_CD_FRAMES  = 15
) (
    input  logic                      clk_pixel_in,
    input  logic                      rst_n_in,
    saber_action_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WINDUP   = 3'd1,
        S_ATTACK   = 3'd2,
        S_RECOVER  = 3'd3,
        S_BLOCK    = 3'd4,
        S_BLOCK_CD = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_count;
    logic [7:0] r_attack_cnt;
    logic       r_btn_prev;
    logic       w_attack_req;
    logic       w_launch;
`ifdef SABER_ATTACK_BUFFER_EN
    logic       r_buf;
`endif

    assign w_attack_req         = bus.attack_btn_in & ~r_btn_prev;
    assign bus.is_attacking     = (r_state == S_ATTACK);
    assign bus.is_blocking      = (r_state == S_BLOCK);
    assign bus.state_out        = r_state;
    assign bus.phase_count_out  = r_count;
    assign bus.attack_count_out = r_attack_cnt;

    // Next-state decode; a timed state leaves on the frame pulse that completes its last frame
    always_comb begin
        w_next   = r_state;
        w_launch = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.block_btn_in) w_next = S_BLOCK;
                else if (w_attack_req) begin
                    w_next   = S_WINDUP;
                    w_launch = 1'b1;
                end
            end
            S_WINDUP:
                if (bus.new_frame_in && r_count == 8'(WINDUP_FRAMES - 1)) w_next = S_ATTACK;
            S_ATTACK:
                if (bus.hit_landed_in || (bus.new_frame_in && r_count == 8'(ATTACK_FRAMES - 1)))
                    w_next = S_RECOVER;
            S_RECOVER:
                if (bus.new_frame_in && r_count == 8'(RECOVER_FRAMES - 1)) begin
`ifdef SABER_ATTACK_BUFFER_EN
                    w_next   = r_buf ? S_WINDUP : S_IDLE;
                    w_launch = r_buf;
`else
                    w_next   = S_IDLE;
`endif
                end
            S_BLOCK:
                if (!bus.block_btn_in || (bus.new_frame_in && r_count == 8'(BLOCK_MAX_FRAMES - 1)))
                    w_next = S_BLOCK_CD;
            S_BLOCK_CD:
                if (bus.new_frame_in && r_count == 8'(BLOCK_CD_FRAMES - 1)) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State, phase counter, strike counter and attack edge register
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= S_IDLE;
            r_count      <= 8'd0;
            r_attack_cnt <= 8'd0;
            r_btn_prev   <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_btn_prev <= bus.attack_btn_in;
            if (w_next != r_state) r_count <= 8'd0;
            else if (bus.new_frame_in && r_count != 8'hFF) r_count <= r_count + 8'd1;
            if (w_launch) r_attack_cnt <= r_attack_cnt + 8'd1;
        end
    end

`ifdef SABER_ATTACK_BUFFER_EN
    // One-entry buffer holding an attack press made while a strike is in progress
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) r_buf <= 1'b0;
        else if (w_next == S_BLOCK && r_state != S_BLOCK) r_buf <= 1'b0;
        else if (w_launch && r_state == S_RECOVER) r_buf <= 1'b0;
        else if (w_attack_req && (r_state == S_WINDUP || r_state == S_ATTACK || r_state == S_RECOVER))
            r_buf <= 1'b1;
    end
`endif
endmodule
